// File: rtl/gcd_controller.sv
// Sequencing FSM for the modulo-based GCD datapath: orders the operands with
// ALU max/min passes, then runs modulo steps until the datapath reports a zero remainder.
module gcd_controller #(
  parameter int MOD_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       modulo_ready_i,
  input  logic       valid_i,
  output logic [2:0] alu_mode_o,
  output logic       modulo_start_o,
  output logic       wren_initial_o,
  output logic       wren_zw_gross_o,
  output logic       wren_zw_klein_o,
  output logic       wren_zw_in_zahlen_o,
  output logic       wren_erg_modulo_o,
  output logic       wren_Zahl_o,
  output logic       wren_to_new_numbers_o,
  output logic       Zahl1_to_alu_a_o,
  output logic       Zahl2_to_alu_b_o,
  output logic       check_for_termination_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam logic [2:0] MODE_IDLE = 3'd0;
  localparam logic [2:0] MODE_MAX  = 3'd1;
  localparam logic [2:0] MODE_MIN  = 3'd2;
  localparam logic [2:0] MODE_MOD  = 3'd3;
  localparam int         CNT_W     = $clog2(MOD_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_SEL_MAX,
    S_SEL_MIN,
    S_WB_MIN,
    S_ORDER,
    S_MOD_START,
    S_MOD_WAIT,
    S_MOD_WB,
    S_CHECK,
    S_SHIFT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  // The current MOD_WAIT cycle is the MOD_TIMEOUT-th one, so the counter
  // reaches MOD_TIMEOUT on the edge that leaves for ERROR.
  assign timeout = (wait_cnt == CNT_W'(MOD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)                   wait_cnt <= '0;
    else if (state == S_MOD_START) wait_cnt <= '0;
    else if (state == S_MOD_WAIT)  wait_cnt <= wait_cnt + CNT_W'(1);
  end

  always_comb begin
    state_nxt               = state;
    alu_mode_o              = MODE_IDLE;
    modulo_start_o          = 1'b0;
    wren_initial_o          = 1'b0;
    wren_zw_gross_o         = 1'b0;
    wren_zw_klein_o         = 1'b0;
    wren_zw_in_zahlen_o     = 1'b0;
    wren_erg_modulo_o       = 1'b0;
    wren_Zahl_o             = 1'b0;
    wren_to_new_numbers_o   = 1'b0;
    Zahl1_to_alu_a_o        = 1'b0;
    Zahl2_to_alu_b_o        = 1'b0;
    check_for_termination_o = 1'b0;
    ready_o                 = 1'b0;
    busy_o                  = (state != S_IDLE);
    done_o                  = 1'b0;
    error_o                 = 1'b0;

    unique case (state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (start_i) state_nxt = S_LOAD;
      end
      S_LOAD: state_nxt = S_INIT;
      S_INIT: begin
        wren_initial_o = 1'b1;
        state_nxt      = S_SEL_MAX;
      end
      S_SEL_MAX: begin
        Zahl1_to_alu_a_o = 1'b1;
        Zahl2_to_alu_b_o = 1'b1;
        alu_mode_o       = MODE_MAX;
        state_nxt        = S_SEL_MIN;
      end
      S_SEL_MIN: begin
        Zahl1_to_alu_a_o = 1'b1;
        Zahl2_to_alu_b_o = 1'b1;
        alu_mode_o       = MODE_MIN;
        wren_zw_gross_o  = 1'b1;
        state_nxt        = S_WB_MIN;
      end
      S_WB_MIN: begin
        wren_zw_klein_o = 1'b1;
        state_nxt       = S_ORDER;
      end
      S_ORDER: begin
        wren_zw_in_zahlen_o = 1'b1;
        state_nxt           = S_MOD_START;
      end
      S_MOD_START: begin
        Zahl1_to_alu_a_o = 1'b1;
        Zahl2_to_alu_b_o = 1'b1;
        alu_mode_o       = MODE_MOD;
        modulo_start_o   = 1'b1;
        state_nxt        = S_MOD_WAIT;
      end
      S_MOD_WAIT: begin
        // Operands and mode stay up through the ready cycle so the ALU
        // output register captures the remainder; ready beats timeout.
        Zahl1_to_alu_a_o = 1'b1;
        Zahl2_to_alu_b_o = 1'b1;
        alu_mode_o       = MODE_MOD;
        if (modulo_ready_i) state_nxt = S_MOD_WB;
        else if (timeout)   state_nxt = S_ERROR;
      end
      S_MOD_WB: begin
        wren_erg_modulo_o = 1'b1;
        state_nxt         = S_CHECK;
      end
      S_CHECK: begin
        check_for_termination_o = 1'b1;
        state_nxt               = valid_i ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        wren_Zahl_o           = 1'b1;
        wren_to_new_numbers_o = 1'b1;
        state_nxt             = S_MOD_START;
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERROR: begin
        error_o   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/gcd_controller.md
# gcd_controller

Sequencing FSM for the modulo-based GCD datapath: it drives the datapath's write-enable, register-transfer, ALU-mode and modulo-start controls to run the Euclidean algorithm on the two operand inputs. It orders the operands with ALU max/min passes, then iterates modulo steps until the datapath flags a zero remainder. It returns a start/ready/done/error handshake to the system. It sits between the top-level start logic and the datapath; `valid_i` and `modulo_ready_i` come from the datapath.

## Interface
- MODE_IDLE, 3'd0, ALU mode driven when no operation is selected
- MODE_MAX, 3'd1, ALU mode: res = max(a,b)
- MODE_MIN, 3'd2, ALU mode: res = min(a,b)
- MODE_MOD, 3'd3, ALU mode: res = a mod b (multi-cycle, modulo_start/modulo_ready handshake)
- MOD_TIMEOUT, 64, max MOD_WAIT cycles before abort; counter width $clog2(MOD_TIMEOUT+1)

Ports:
- clk  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  request; sampled only in IDLE
- modulo_ready_i  in  1  ALU modulo result valid
- valid_i  in  1  datapath termination flag (check & remainder==0)
- alu_mode_o  out  3  ALU mode
- modulo_start_o  out  1  one-cycle modulo start pulse
- wren_initial_o, wren_zw_gross_o, wren_zw_klein_o, wren_zw_in_zahlen_o, wren_erg_modulo_o, wren_Zahl_o, wren_to_new_numbers_o  out  1 each  datapath write-backs
- Zahl1_to_alu_a_o, Zahl2_to_alu_b_o  out  1 each  operand selects
- check_for_termination_o  out  1  qualifies valid_i
- ready_o  out  1  high in IDLE
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse; datapath `ergebnis_o` holds the GCD from this cycle until the next start
- error_o  out  1  one-cycle pulse on modulo timeout

## Operation
- Moore FSM. All outputs decode from the state register only.
- Outputs not listed for a state are 0, and alu_mode_o = MODE_IDLE.
- States:
  - IDLE: ready_o. Goes to LOAD on start_i.
  - LOAD: 1 cycle, lets the datapath input registers capture Zahl1_i/Zahl2_i.
  - INIT: wren_initial_o.
  - SEL_MAX: both selects, MODE_MAX.
  - SEL_MIN: both selects, MODE_MIN, wren_zw_gross_o (writes the max).
  - WB_MIN: wren_zw_klein_o.
  - ORDER: wren_zw_in_zahlen_o. Sets Zahl1 = big, Zahl2 = small, result = small.
  - MOD_START: both selects, MODE_MOD, modulo_start_o.
  - MOD_WAIT: both selects, MODE_MOD. Goes to MOD_WB on modulo_ready_i. Goes to ERROR when the counter reaches MOD_TIMEOUT.
  - MOD_WB: wren_erg_modulo_o.
  - CHECK: check_for_termination_o. Goes to DONE if valid_i, else SHIFT.
  - SHIFT: wren_Zahl_o and wren_to_new_numbers_o together. Sets Zahl1 = Zahl2, Zahl2 = remainder, result = remainder. Then returns to MOD_START.
  - DONE: done_o, then IDLE.
  - ERROR: error_o, then IDLE.
- modulo_ready_i is ignored outside MOD_WAIT, including in MOD_START.
- Operands and mode are held through the MOD_WAIT cycle in which ready is seen, so the datapath ALU output register captures the remainder.
- Timeout counter:
  - Clears in MOD_START and increments each MOD_WAIT cycle.
  - If modulo_ready_i and the timeout condition occur in the same cycle, ready wins.
- start_i outside IDLE is ignored. It is not queued.
- Precondition: both operands are nonzero, 16-bit unsigned. A zero divisor produces ERROR via timeout, or an unspecified result.

## Timing
- Reset (async assert, any state):
  - State goes to IDLE and the timeout counter to 0.
  - ready_o = 1; every other output = 0; alu_mode_o = MODE_IDLE.
- Reset deassertion is taken synchronously to clk by the system.
- Reset mid-operation abandons the computation: no done_o or error_o, and the datapath contents are don't-care.
- With start_i sampled at edge E0, LOAD is cycle 1, ORDER is cycle 6 and the first MOD_START is cycle 7.
- Each iteration k takes 1 (MOD_START) + W_k (MOD_WAIT, W_k ≥ 1, last cycle has ready) + 1 (MOD_WB) + 1 (CHECK) cycles, plus 1 (SHIFT) on all but the last.
- done_o is asserted in cycle 7 + Σ(W_k + 3) + (N − 1) after E0, for N iterations.
- ready_o rises in the cycle after DONE or ERROR. Back-to-back starts are accepted from that cycle.

## Test plan
- Zahl1=48, Zahl2=18, modulo_ready after 1 wait cycle each -> 3 iterations (12, 6, 0), done_o in cycle 21 after E0, ergebnis = 6, modulo_start_o pulsed exactly 3 times.
- Zahl1=18, Zahl2=48 (swapped) -> identical control trace and timing, ergebnis = 6.
- Zahl1=7, Zahl2=7 -> one iteration, remainder 0 at first CHECK, no SHIFT, done_o at cycle 11, ergebnis = 7.
- Zahl1=17, Zahl2=5, random modulo latency 1–10 -> remainders 2, 1, 0, ergebnis = 1, done_o at the cycle given by the Timing formula; start_i pulses during busy are ignored.
- modulo_ready_i held low -> error_o one cycle after 64 MOD_WAIT cycles, no done_o, ready_o = 1 next cycle. A following 48/18 run then completes normally with ergebnis = 6.
- rst_ni asserted asynchronously mid-MOD_WAIT -> outputs take reset values immediately, without a clock edge. After release, a new 48/18 run completes with ergebnis = 6.
